mult_share_ctrl: RTL and testbench
==================================

# mult_share_ctrl

Sequencing controller and two-port round-robin arbiter for the team's 8×8 shift-add multiplier. It lets two independent requesters, such as a switch-input channel and a test-pattern generator, share one multiplier instance. It captures a winner's operands, drives the multiplier's load_a / load_b / start pulse protocol, waits for done, and returns the 16-bit product with a one-cycle acknowledge. It sits between the requesters and the multiplier; the BCD/7-segment display path stays on the multiplier's own outputs.

## Interface
- PULSE_W, 1: width in cycles of each load_a / load_b / start pulse (1..15).
- TIMEOUT, 64: maximum cycles to wait for mul_done before an error response (8..255).
- clk  in  1  system clock.
- clrn  in  1  asynchronous, active-low reset.
- req0, req1  in  1  request level; operands must be stable while req is high and not yet granted.
- a0, b0, a1, b1  in  8  operands for each requester.
- ack0, ack1  out  1  one-cycle pulse: result is valid for that port.
- err0, err1  out  1  valid with ack; set when the multiplier timed out.
- result0, result1  out  16  registered product; holds until that port's next ack.
- busy  out  1  high in every state except IDLE.
- mul_a, mul_b  out  8  operand buses to the multiplier.
- mul_load_a, mul_load_b, mul_start  out  1  control pulses to the multiplier.
- mul_p  in  16  multiplier product.
- mul_done  in  1  multiplier done. It is a level: low after start, high when the product is valid, and held until the next start.

## Operation
- The states are IDLE, LOAD_A, LOAD_B, START, WAIT and RESP.
- **IDLE:** if any req is high, grant one requester.
  - If both are high, grant the port other than `last`.
  - `last` is 1 at reset, so req0 wins the first tie.
  - On grant: latch the operands into op_a/op_b, latch the port id into `cur`, set `last`=cur, and go to LOAD_A.
- **LOAD_A:** mul_a=op_a, mul_load_a=1 for PULSE_W cycles, then go to LOAD_B.
- **LOAD_B:** mul_b=op_b, mul_load_b=1 for PULSE_W cycles, then go to START.
- **START:** mul_start=1 for PULSE_W cycles, then go to WAIT. Clear the `seen_low` flag and the timeout counter on entry.
- **WAIT:**
  - Set `seen_low` when mul_done is sampled 0.
  - When mul_done=1 and seen_low=1, capture mul_p into result[cur], clear err[cur], and go to RESP.
  - If the counter reaches TIMEOUT first, set result[cur]=16'hFFFF and err[cur]=1, and go to RESP.
- **RESP:** ack[cur]=1 for exactly one cycle, then go to IDLE.
- mul_a/mul_b keep their last driven values outside their load states.
- Operands are captured at grant. Dropping req or changing operands after grant does not abort the operation; the ack is still issued.
- A req held high after its ack is a new request and is arbitrated again in IDLE.
- The arbiter is strictly alternating under continuous contention: no port is served twice in a row while the other is requesting.
- Arithmetic is unsigned. The product is taken from mul_p unmodified. The controller does no widening or truncation.

## Timing
- All outputs are registered.
- Reset values:
  - ack, err, busy, mul_load_a, mul_load_b, mul_start: 0.
  - result0, result1, mul_a, mul_b: 0.
  - State is IDLE, `last`=1.
- Latency from the first cycle req is seen in IDLE to ack: 1 (grant) + 3×PULSE_W + WAIT cycles + 1 (RESP).
- WAIT lasts at least 2 cycles, because seen_low must be observed first.
- With PULSE_W=1 and a multiplier done 8 cycles after start, req-to-ack is 13 cycles.
- Back-to-back operation: IDLE is one cycle minimum between RESP and the next grant, so a grant can occur the cycle after the ack.
- Asserting clrn low mid-operation:
  - Immediately returns to IDLE and clears all outputs.
  - The in-flight request is dropped with no ack.
  - Requesters must re-request after release.
- Asynchronous assert, synchronous deassert is expected from the system reset synchronizer.

## Structure
- Package `mult_share_pkg`: the state enum, the PORT0/PORT1 constants, the 16'hFFFF error code, and the PULSE_W/TIMEOUT bounds.
- Sub-module `rr_arb2`: combinational two-request round-robin pick. Inputs are req[1:0] and last; outputs are gnt_valid and gnt_id. The main FSM owns the `last` register.
- Counters:
  - pulse_cnt: 4 bits, shared by LOAD_A/LOAD_B/START.
  - to_cnt: 8 bits.

## Test plan
- **Single request:** req0, a0=62, b0=3; behavioral multiplier with done 8 cycles after start → mul_load_a, mul_load_b and mul_start each pulse 1 cycle in order; ack0 at cycle 13, result0=186, err0=0, no ack1.
- **Tie after reset:** req0 (5×7) and req1 (125×2) raised in the same cycle → ack0 first with 35, then ack1 with 250; `last` toggles; busy is continuous except one IDLE cycle.
- **Continuous contention:** both req held high for 6 operations → acks alternate 0,1,0,1,0,1. Includes 255×255 → 65025.
- **Timeout:** model never raises mul_done → ack after TIMEOUT WAIT cycles with result=16'hFFFF and err=1; the next request completes normally.
- **Stale done / req drop:** mul_done held high from the previous op until start, then low for 3 cycles, then high → no early capture, correct product. Also, req1 dropped the cycle after grant → ack1 is still issued with the product of the latched operands.
- **Reset mid-operation:** clrn pulsed low during WAIT → all outputs 0 asynchronously, no ack, state IDLE. After release, req0 (4×4) → result0=16.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared types and constants for the two-port multiplier sharing controller.
// The state encoding, port ids, error code and parameter bounds all live here.
package mult_share_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam logic [15:0] ERR_CODE = 16'hFFFF;

  localparam int PULSE_W_MIN = 1;
  localparam int PULSE_W_MAX = 15;
  localparam int TIMEOUT_MIN = 8;
  localparam int TIMEOUT_MAX = 255;

  // Select one requester's operand byte by port id.
  function automatic logic [7:0] sel8(input logic id, input logic [7:0] x0, input logic [7:0] x1);
    logic [7:0] r;
    if (id == PORT1) begin
      r = x1;
    end else begin
      r = x0;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-request round-robin pick; a tie goes to the port that was not served last.
module rr_arb2
  import mult_share_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Decode the request pair into a grant
  always_comb begin
    gnt_valid = |req;
    case (req)
      2'b01:   gnt_id = PORT0;
      2'b10:   gnt_id = PORT1;
      2'b11:   gnt_id = ~last;
      default: gnt_id = PORT0;
    endcase
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Sequencer and round-robin front end letting two requesters share one shift-add multiplier.
// Outputs are registered from next-state values so they line up with the state they belong to.
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int PULSE_W = 1,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  a0,
  input  logic [7:0]  b0,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [15:0] result0,
  output logic [15:0] result1,
  output logic        busy,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  output logic        mul_load_a,
  output logic        mul_load_b,
  output logic        mul_start,
  input  logic [15:0] mul_p,
  input  logic        mul_done
);

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_W - 1);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  state_e      state_r, next_state_s;
  logic        last_r, cur_r;
  logic [7:0]  op_a_r, op_b_r;
  logic [3:0]  pulse_cnt_r;
  logic [7:0]  to_cnt_r;
  logic        seen_low_r;

  logic        gnt_valid_s, gnt_id_s, grant_s;
  logic        pulse_done_s, pulse_run_s, done_ok_s, to_hit_s;
  logic [7:0]  op_a_nx_s, op_b_nx_s;
  logic        capture_s;
  logic [15:0] cap_val_s;
  logic        ack0_nx_s, ack1_nx_s, err0_nx_s, err1_nx_s, busy_nx_s;
  logic [15:0] result0_nx_s, result1_nx_s;
  logic [7:0]  mul_a_nx_s, mul_b_nx_s;
  logic        load_a_nx_s, load_b_nx_s, start_nx_s;

  rr_arb2 u_arb (
    .req       ({req1, req0}),
    .last      (last_r),
    .gnt_valid (gnt_valid_s),
    .gnt_id    (gnt_id_s)
  );

  assign grant_s      = (state_r == ST_IDLE) && gnt_valid_s;
  assign pulse_done_s = (pulse_cnt_r == PULSE_LAST);
  assign pulse_run_s  = ((state_r == ST_LOAD_A) || (state_r == ST_LOAD_B) || (state_r == ST_START))
                        && (next_state_s == state_r);
  // A done level only counts once it has been seen low after start; a stale high is ignored.
  assign done_ok_s    = mul_done && seen_low_r;
  assign to_hit_s     = (to_cnt_r == TO_LAST);
  assign op_a_nx_s    = grant_s ? sel8(gnt_id_s, a0, a1) : op_a_r;
  assign op_b_nx_s    = grant_s ? sel8(gnt_id_s, b0, b1) : op_b_r;

  // State register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:   next_state_s = gnt_valid_s  ? ST_LOAD_A : ST_IDLE;
      ST_LOAD_A: next_state_s = pulse_done_s ? ST_LOAD_B : ST_LOAD_A;
      ST_LOAD_B: next_state_s = pulse_done_s ? ST_START  : ST_LOAD_B;
      ST_START:  next_state_s = pulse_done_s ? ST_WAIT   : ST_START;
      ST_WAIT: begin
        if (done_ok_s || to_hit_s) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_RESP:   next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Grant bookkeeping, pulse/timeout counters and the seen-low flag
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      last_r      <= PORT1;
      cur_r       <= PORT0;
      op_a_r      <= 8'd0;
      op_b_r      <= 8'd0;
      pulse_cnt_r <= 4'd0;
      to_cnt_r    <= 8'd0;
      seen_low_r  <= 1'b0;
    end else begin
      op_a_r <= op_a_nx_s;
      op_b_r <= op_b_nx_s;
      if (grant_s) begin
        cur_r  <= gnt_id_s;
        last_r <= gnt_id_s;
      end else begin
        cur_r  <= cur_r;
        last_r <= last_r;
      end
      if (pulse_run_s) begin
        pulse_cnt_r <= pulse_cnt_r + 4'd1;
      end else begin
        pulse_cnt_r <= 4'd0;
      end
      if (next_state_s == ST_START) begin
        to_cnt_r   <= 8'd0;
        seen_low_r <= 1'b0;
      end else if (state_r == ST_WAIT) begin
        to_cnt_r   <= to_cnt_r + 8'd1;
        seen_low_r <= seen_low_r | ~mul_done;
      end else begin
        to_cnt_r   <= to_cnt_r;
        seen_low_r <= seen_low_r;
      end
    end
  end

  // Next values of every registered output
  always_comb begin
    capture_s    = (state_r == ST_WAIT) && (next_state_s == ST_RESP);
    cap_val_s    = done_ok_s ? mul_p : ERR_CODE;
    ack0_nx_s    = (next_state_s == ST_RESP) && (cur_r == PORT0);
    ack1_nx_s    = (next_state_s == ST_RESP) && (cur_r == PORT1);
    result0_nx_s = (capture_s && (cur_r == PORT0)) ? cap_val_s  : result0;
    result1_nx_s = (capture_s && (cur_r == PORT1)) ? cap_val_s  : result1;
    err0_nx_s    = (capture_s && (cur_r == PORT0)) ? !done_ok_s : err0;
    err1_nx_s    = (capture_s && (cur_r == PORT1)) ? !done_ok_s : err1;
    busy_nx_s    = (next_state_s != ST_IDLE);
    mul_a_nx_s   = (next_state_s == ST_LOAD_A) ? op_a_nx_s : mul_a;
    mul_b_nx_s   = (next_state_s == ST_LOAD_B) ? op_b_nx_s : mul_b;
    load_a_nx_s  = (next_state_s == ST_LOAD_A);
    load_b_nx_s  = (next_state_s == ST_LOAD_B);
    start_nx_s   = (next_state_s == ST_START);
  end

  // Output registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      result0    <= 16'd0;
      result1    <= 16'd0;
      busy       <= 1'b0;
      mul_a      <= 8'd0;
      mul_b      <= 8'd0;
      mul_load_a <= 1'b0;
      mul_load_b <= 1'b0;
      mul_start  <= 1'b0;
    end else begin
      ack0       <= ack0_nx_s;
      ack1       <= ack1_nx_s;
      err0       <= err0_nx_s;
      err1       <= err1_nx_s;
      result0    <= result0_nx_s;
      result1    <= result1_nx_s;
      busy       <= busy_nx_s;
      mul_a      <= mul_a_nx_s;
      mul_b      <= mul_b_nx_s;
      mul_load_a <= load_a_nx_s;
      mul_load_b <= load_b_nx_s;
      mul_start  <= start_nx_s;
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Scoreboard bench for mult_share_ctrl: requesters push expected responses, a monitor pops on ack.
// A behavioural multiplier with configurable done delay, stale-done lag and never-done mode drives mul_p/mul_done.
module tb_mult_share_ctrl;

  typedef struct packed {
    logic [15:0] r;
    logic        e;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    bit         to;
    bit         drop;
    bit         hold;
    int         gap;
  } op_t;

  logic        clk, clrn, req0, req1;
  logic [7:0]  a0, b0, a1, b1;
  logic        ack0, ack1, err0, err1, busy;
  logic [15:0] result0, result1;
  logic [7:0]  mul_a, mul_b;
  logic        mul_load_a, mul_load_b, mul_start;
  logic [15:0] mul_p;
  logic        mul_done;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp0[$], exp1[$];
  op_t  ops0[$], ops1[$];
  int   ack_order[$], idle_q[$];
  int   idle_cnt = 0;
  int   last_lat[2];

  // behavioural multiplier state
  int          mdl_delay = 8;
  bit          mdl_never = 1'b0;
  bit          mdl_lag   = 1'b0;
  logic [7:0]  ma = 8'd0, mb = 8'd0;
  int          rem = 0;
  logic        done_raw = 1'b0, done_dly = 1'b0;

  mult_share_ctrl #(.PULSE_W(1), .TIMEOUT(64)) dut (
    .clk(clk), .clrn(clrn), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .result0(result0), .result1(result1), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_load_a(mul_load_a), .mul_load_b(mul_load_b), .mul_start(mul_start),
    .mul_p(mul_p), .mul_done(mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mul_done = mdl_lag ? done_dly : done_raw;

  // Multiplier model: done drops at the sampled start, rises mdl_delay cycles after the start cycle
  always @(posedge clk) begin
    if (mul_load_a) ma <= mul_a;
    if (mul_load_b) mb <= mul_b;
    if (mul_start) begin
      done_raw <= 1'b0;
      rem      <= (mdl_delay == 0) ? int'($urandom_range(11, 1)) : mdl_delay - 1;
    end else if (rem > 0) begin
      if (rem == 1 && !mdl_never) begin
        done_raw <= 1'b1;
        mul_p    <= 16'(ma) * 16'(mb);
      end
      rem <= rem - 1;
    end
    done_dly <= done_raw;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic score(input int p, input logic [15:0] res, input logic er);
    exp_t e;
    if ((p == 0 && exp0.size() == 0) || (p == 1 && exp1.size() == 0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_ack%0d: got ack with result %0h, required no ack", p, res);
    end else begin
      e = (p == 0) ? exp0.pop_front() : exp1.pop_front();
      check($sformatf("result%0d", p), 32'(res), 32'(e.r));
      check($sformatf("err%0d", p), 32'(er), 32'(e.e));
    end
  endtask

  // Monitor: compares every ack against the scoreboard and logs ack order and idle gaps
  always @(negedge clk) begin
    if (!busy) idle_cnt++;
    if (ack0) begin
      score(0, result0, err0);
      ack_order.push_back(0);
      idle_q.push_back(idle_cnt);
      idle_cnt = 0;
    end
    if (ack1) begin
      score(1, result1, err1);
      ack_order.push_back(1);
      idle_q.push_back(idle_cnt);
      idle_cnt = 0;
    end
  end

  task automatic drive(input int p, input logic r, input logic [7:0] a, input logic [7:0] b);
    if (p == 0) begin req0 = r; a0 = a; b0 = b; end
    else begin req1 = r; a1 = a; b1 = b; end
  endtask

  task automatic add_op(input int p, input logic [7:0] a, input logic [7:0] b,
                        input bit to, input bit drop, input bit hold, input int gap);
    op_t o;
    o.a = a; o.b = b; o.to = to; o.drop = drop; o.hold = hold; o.gap = gap;
    if (p == 0) ops0.push_back(o); else ops1.push_back(o);
  endtask

  // Requester: issues its queued ops, pushing the reference response for each
  task automatic run_port(input int p);
    op_t  o;
    exp_t e;
    int   k;
    bit   got;
    @(negedge clk);
    while ((p == 0) ? (ops0.size() > 0) : (ops1.size() > 0)) begin
      o = (p == 0) ? ops0.pop_front() : ops1.pop_front();
      drive(p, 1'b1, o.a, o.b);
      e.r = o.to ? 16'hFFFF : 16'(o.a) * 16'(o.b);
      e.e = o.to;
      if (p == 0) exp0.push_back(e); else exp1.push_back(e);
      k = 0;
      got = 1'b0;
      if (o.drop) begin
        @(negedge clk);
        k++;
        drive(p, 1'b0, 8'($urandom), 8'($urandom));
      end
      while (!got && k < 400) begin
        @(negedge clk);
        k++;
        got = (p == 0) ? ack0 : ack1;
      end
      if (!got) begin
        n_tests++;
        n_fail++;
        $display("FAIL ack_wait%0d: no ack after %0d cycles, required an ack", p, k);
      end
      last_lat[p] = k;
      if (!o.hold || ((p == 0) ? (ops0.size() == 0) : (ops1.size() == 0))) begin
        drive(p, 1'b0, 8'($urandom), 8'($urandom));
        repeat (o.gap) @(negedge clk);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack0"}, 32'(ack0), 32'd0);
    check({tag, "_ack1"}, 32'(ack1), 32'd0);
    check({tag, "_err0"}, 32'(err0), 32'd0);
    check({tag, "_err1"}, 32'(err1), 32'd0);
    check({tag, "_result0"}, 32'(result0), 32'd0);
    check({tag, "_result1"}, 32'(result1), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_mul_a"}, 32'(mul_a), 32'd0);
    check({tag, "_mul_b"}, 32'(mul_b), 32'd0);
    check({tag, "_ctl"}, 32'({mul_load_a, mul_load_b, mul_start}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    drive(0, 1'b0, 8'd0, 8'd0);
    drive(1, 1'b0, 8'd0, 8'd0);
    repeat (2) @(negedge clk);
    clrn = 1'b1;
  endtask

  // Pulse tracker for a single isolated op: cycle index (from the req cycle) and count of each pulse
  task automatic track_pulses();
    int la_i = -1, lb_i = -1, st_i = -1, la_n = 0, lb_n = 0, st_n = 0;
    logic [7:0] la_v = 8'd0, lb_v = 8'd0;
    @(negedge clk);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (mul_load_a) begin la_n++; if (la_i < 0) begin la_i = i; la_v = mul_a; end end
      if (mul_load_b) begin lb_n++; if (lb_i < 0) begin lb_i = i; lb_v = mul_b; end end
      if (mul_start)  begin st_n++; if (st_i < 0) st_i = i; end
    end
    check("load_a_cycle", 32'(la_i), 32'd1);
    check("load_b_cycle", 32'(lb_i), 32'd2);
    check("start_cycle", 32'(st_i), 32'd3);
    check("pulse_counts", 32'({8'(la_n), 8'(lb_n), 8'(st_n)}), 32'h010101);
    check("mul_a_at_load", 32'(la_v), 32'd62);
    check("mul_b_at_load", 32'(lb_v), 32'd3);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    clrn = 1'b0;
    drive(0, 1'b0, 8'd0, 8'd0);
    drive(1, 1'b0, 8'd0, 8'd0);
    #1;
    check_zero("reset");
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (2) @(negedge clk);

    // single request, done 8 cycles after start: ack on the 13th cycle counting the req cycle
    mdl_delay = 8;
    add_op(0, 8'd62, 8'd3, 1'b0, 1'b0, 1'b0, 3);
    fork
      run_port(0);
      track_pulses();
    join
    check("single_latency", 32'(last_lat[0] + 1), 32'd13);

    // tie straight after reset: port0 first, then port1 after exactly one idle cycle
    do_reset();
    mdl_delay = 0;
    ack_order.delete();
    idle_q.delete();
    add_op(0, 8'd5, 8'd7, 1'b0, 1'b0, 1'b0, 2);
    add_op(1, 8'd125, 8'd2, 1'b0, 1'b0, 1'b0, 2);
    fork
      run_port(0);
      run_port(1);
    join
    check("tie_order", 32'({ack_order.size(), ack_order[0], ack_order[1]}), 32'({32'd2, 32'd0, 32'd1}));
    check("tie_idle_gap", 32'(idle_q[1]), 32'd1);

    // continuous contention with both reqs held: strict alternation
    ack_order.delete();
    add_op(0, 8'd255, 8'd255, 1'b0, 1'b0, 1'b1, 2);
    add_op(1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1, 2);
    for (int i = 0; i < 2; i++) begin
      add_op(0, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1, 2);
      add_op(1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1, 2);
    end
    fork
      run_port(0);
      run_port(1);
    join
    check("contention_count", 32'(ack_order.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < ack_order.size()) check($sformatf("contention_ack%0d", i), 32'(ack_order[i]), 32'(i % 2));

    // timeout: never-done multiplier, then a normal op on the other port
    mdl_never = 1'b1;
    add_op(0, 8'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0, 2);
    run_port(0);
    check("timeout_latency", 32'(last_lat[0] + 1), 32'd69);
    mdl_never = 1'b0;
    mdl_delay = 5;
    add_op(1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 2);
    run_port(1);

    // stale done high into WAIT, then req dropped right after grant
    mdl_lag = 1'b1;
    mdl_delay = 4;
    add_op(0, 8'($urandom_range(255, 1)), 8'($urandom_range(255, 1)), 1'b0, 1'b0, 1'b0, 2);
    run_port(0);
    mdl_lag = 1'b0;
    add_op(1, 8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b0, 2);
    run_port(1);

    // reset during WAIT: everything clears asynchronously and no ack follows
    mdl_delay = 8;
    @(negedge clk);
    drive(0, 1'b1, 8'd9, 8'd9);
    @(negedge clk);
    drive(0, 1'b0, 8'd0, 8'd0);
    repeat (5) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    #2;
    clrn = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    repeat (20) @(negedge clk);
    add_op(0, 8'd4, 8'd4, 1'b0, 1'b0, 1'b0, 2);
    run_port(0);

    // randomized traffic on both ports with random done delays
    mdl_delay = 0;
    for (int i = 0; i < 12; i++) begin
      add_op(0, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'($urandom), int'($urandom_range(3, 0)));
      add_op(1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'($urandom), int'($urandom_range(3, 0)));
    end
    fork
      run_port(0);
      run_port(1);
    join

    repeat (5) @(negedge clk);
    check("exp0_drained", 32'(exp0.size()), 32'd0);
    check("exp1_drained", 32'(exp1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
